// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Desc    : Shared UART types, frame constants and Baud_set-to-divisor map.
//           Frame layout depends on macro UART_SEND_PARITY_EN.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

  localparam int DIV_W = 16;

`ifdef UART_SEND_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_t;
`endif

  // Codes 5-7 fall back to the fastest rate so the line never stalls.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] baud_set,
                                                input int unsigned clk_freq);
    int unsigned rate;
    case (baud_set)
      3'd1:    rate = 57600;
      3'd2:    rate = 38400;
      3'd3:    rate = 19200;
      3'd4:    rate = 9600;
      default: rate = 115200;
    endcase
    return DIV_W'(clk_freq / rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_gen
// Desc   : Bit-period counter; pulses bit_end on the last clock of each bit.
// Rev    : 1.0
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             sysclk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  input  logic             clr,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last    = div - DIV_W'(1);
  assign bit_end = en && (cnt == last);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_send.sv
`default_nettype none
// ============================================================================
// Module : uart_send
// Desc   : 8N1 UART transmitter; define UART_SEND_PARITY_EN for an even parity bit.
// Rev    : 1.0
// ============================================================================
module uart_send
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  input  logic [7:0] Data,
  input  logic       send_go,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t        state;
  logic [7:0]       data_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic             accept;
  logic             bit_end;

  assign accept = (state == IDLE) && send_go;

  uart_baud_gen u_baud_gen (
    .sysclk  (sysclk),
    .rst     (rst),
    .div     (div_q),
    .en      (state != IDLE),
    .clr     (accept),
    .bit_end (bit_end)
  );

  // Outputs are registered from the current state, so the line lags the
  // state register by one clock; this places bit 0 at accept+1.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_busy <= (state != IDLE);
      tx_done <= tx_busy && (state == IDLE);
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (send_go) begin
            data_q  <= Data;
            div_q   <= baud_div(Baud_set, CLK_FREQ);
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          uart_tx <= data_q[bit_idx];
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_SEND_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_SEND_PARITY_EN
        PARITY: begin
          uart_tx <= ^data_q;
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          uart_tx <= 1'b1;
          if (bit_end) state <= IDLE;
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_send.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_send
// Desc   : Scoreboarded bench for uart_send (line decoded back into bytes).
// Rev    : 1.0
// ============================================================================
module tb_uart_send;

  localparam int NB   = uart_pkg::FRAME_BITS;
  localparam int DIV0 = 434;
  localparam int DIV4 = 5208;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [2:0] Baud_set;
  logic [7:0] Data;
  logic       send_go;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int acc, st, st2;

  logic [7:0] exp_q[$];

  uart_send #(.CLK_FREQ(50_000_000)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .Baud_set (Baud_set),
    .Data     (Data),
    .send_go  (send_go),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_busy === 1'b1) busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge; returns the accepting edge index.
  task automatic send_byte(input logic [7:0] b, input logic [2:0] baud, output int acc_cyc);
    Data     = b;
    Baud_set = baud;
    send_go  = 1'b1;
    exp_q.push_back(b);
    @(negedge sysclk);
    send_go = 1'b0;
    acc_cyc = cyc;
  endtask

  // Decode one frame from the line, checking every bit is flat for div clocks.
  task automatic collect_frame(input int div, output int start_cyc);
    logic [10:0] fr;
    logic        a;
    logic        b;
    logic [7:0]  got;
    logic [7:0]  exp;
    int          waited;
    fr        = '0;
    waited    = 0;
    start_cyc = -1;
    while (uart_tx !== 1'b0 && waited < 3 * div + 20) begin
      @(negedge sysclk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      check_eq("start_seen", uart_tx, 0);
      return;
    end
    start_cyc = cyc;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) @(negedge sysclk);
      a = uart_tx;
      repeat (div - 1) @(negedge sysclk);
      b = uart_tx;
      check_eq($sformatf("bit%0d_width", i), b, a);
      fr[i] = a;
    end
    got = fr[8:1];
    check_eq("start_bit", fr[0], 0);
    check_eq("stop_bit", fr[NB-1], 1);
`ifdef UART_SEND_PARITY_EN
    check_eq("parity_bit", fr[9], ^got);
`endif
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", exp_q.size(), 1);
    end else begin
      exp = exp_q.pop_front();
      check_eq("rx_byte", got, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    send_go  = 1'b0;
    Data     = 8'h00;
    Baud_set = 3'd0;
    repeat (3) @(negedge sysclk);
    check_eq("rst_tx", uart_tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_done", tx_done, 0);
    rst = 1'b0;
    @(negedge sysclk);

    // Single frame at 115200
    done_cnt = 0;
    busy_cnt = 0;
    send_byte(8'hAB, 3'd0, acc);
    collect_frame(DIV0, st);
    check_eq("t1_first_low", st - acc, 1);
    repeat (3) @(negedge sysclk);
    check_eq("t1_done_lat", done_cyc - acc, 1 + NB * DIV0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_busy_cycles", busy_cnt, NB * DIV0);

    // send_go held high: two frames at the minimum period
    done_cnt = 0;
    Data     = 8'hAB;
    Baud_set = 3'd0;
    send_go  = 1'b1;
    exp_q.push_back(8'hAB);
    @(negedge sysclk);
    acc  = cyc;
    Data = 8'hCD;
    exp_q.push_back(8'hCD);
    fork
      begin
        collect_frame(DIV0, st);
        collect_frame(DIV0, st2);
      end
      begin
        while (cyc < acc + NB * DIV0 + 1) @(negedge sysclk);
        send_go = 1'b0;
      end
    join
    repeat (3) @(negedge sysclk);
    check_eq("t2_first_low", st - acc, 1);
    check_eq("t2_period", st2 - st, NB * DIV0 + 1);
    check_eq("t2_done_cnt", done_cnt, 2);

    // 9600 baud with mid-frame input changes and a stray send_go
    done_cnt = 0;
    busy_cnt = 0;
    send_byte(8'h55, 3'd4, acc);
    fork
      collect_frame(DIV4, st);
      begin
        repeat (2 * DIV4 + 100) @(negedge sysclk);
        Baud_set = 3'd0;
        Data     = 8'hFF;
        send_go  = 1'b1;
        @(negedge sysclk);
        send_go = 1'b0;
      end
    join
    repeat (3) @(negedge sysclk);
    check_eq("t3_done_lat", done_cyc - acc, 1 + NB * DIV4);
    check_eq("t3_busy_cycles", busy_cnt, NB * DIV4);
    repeat (50) @(negedge sysclk);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_idle_tx", uart_tx, 1);
    check_eq("t3_idle_busy", tx_busy, 0);

    // Reset during D3 aborts the frame without tx_done
    done_cnt = 0;
    send_byte(8'hA5, 3'd0, acc);
    void'(exp_q.pop_back());  // aborted frame never reaches the line decoder
    while (cyc < acc + 1 + 4 * DIV0 + 200) @(negedge sysclk);
    check_eq("t4_pre_busy", tx_busy, 1);
    check_eq("t4_pre_tx_d3", uart_tx, 0);
    #3 rst = 1'b1;
    #1;
    check_eq("t4_rst_tx", uart_tx, 1);
    check_eq("t4_rst_busy", tx_busy, 0);
    check_eq("t4_rst_done", tx_done, 0);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (3 * DIV0) @(negedge sysclk);
    check_eq("t4_no_done", done_cnt, 0);
    check_eq("t4_idle_tx", uart_tx, 1);

    // Clean frame after reset release
    done_cnt = 0;
    busy_cnt = 0;
    send_byte(8'h96, 3'd0, acc);
    collect_frame(DIV0, st);
    check_eq("t5_first_low", st - acc, 1);
    repeat (3) @(negedge sysclk);
    check_eq("t5_done_lat", done_cyc - acc, 1 + NB * DIV0);
    check_eq("t5_done_cnt", done_cnt, 1);
    check_eq("t5_busy_cycles", busy_cnt, NB * DIV0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_send.md
# uart_send

UART transmitter. Serialises one byte per request into an 8N1 frame on `uart_tx` at a selectable baud rate. Sits directly upstream of the `recieve` block and shares its 50 MHz `sysclk` domain, `Baud_set` encoding and bit timing, so that its line can drive `recieve`'s `uart_rx` in loopback.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz; used to derive the baud divisors.

Ports:
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `Baud_set`  in  3  baud select, sampled on accept:
  - 0: 115200, DIV 434
  - 1: 57600, DIV 868
  - 2: 38400, DIV 1302
  - 3: 19200, DIV 2604
  - 4: 9600, DIV 5208
  - 5–7: 115200, DIV 434
- `Data`  in  8  byte to send; sampled on accept.
- `send_go`  in  1  request strobe; level-sampled each edge.
- `uart_tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States are IDLE, START, DATA, STOP (plus PARITY when the parity feature is compiled in).
- **IDLE:**
  - `uart_tx`=1 and `tx_busy`=0.
  - When `send_go`=1 at an edge, the block latches `Data` and the divisor selected by `Baud_set`, then moves to START.
- **START:** `uart_tx`=0 for DIV clocks, then DATA.
- **DATA:**
  - Sends `Data[0]` first through `Data[7]`, DIV clocks each.
  - A 3-bit index counts 0 to 7 and does not wrap. After bit 7 the block moves to STOP.
- **STOP:** `uart_tx`=1 for DIV clocks, then IDLE with `tx_done` pulsed.
- **Baud counter:** width ≥13 bits. It counts 0 to DIV−1, reloads to 0 at each bit boundary, and resets to 0 on accept.
- **Mid-frame input changes:** `send_go`, `Data` and `Baud_set` are ignored while `tx_busy`=1. A new frame is never queued.
- **Reset:**
  - Asserting `rst` at any time, including mid-frame, forces IDLE immediately.
  - `uart_tx`=1, `tx_busy`=0, `tx_done`=0 and all counters clear.
  - A frame aborted by reset produces no `tx_done`.

## Timing
- Reset values: `uart_tx`=1, `tx_busy`=0, `tx_done`=0.
- Accept at edge k:
  - `uart_tx` falls and `tx_busy` rises at edge k+1.
  - Frame bit i (start=0, D0..D7=1..8, stop=9) spans edges k+1+i·DIV to k+1+(i+1)·DIV.
- Frame end:
  - At edge k+1+10·DIV, `tx_done` rises for exactly one cycle and `tx_busy` falls; `uart_tx` stays 1.
- Back-to-back frames:
  - If `send_go` is high during the `tx_done` cycle, it is accepted at the next edge.
  - Minimum frame period is therefore 10·DIV+1 clocks, with at least one idle clock of high line between frames.
- `send_go` held high continuously sends repeated frames at that minimum period.
- At DIV 434, one bit is 8680 ns, which matches the bit period `recieve` expects at `Baud_set`=0.

## Configuration
- Macro: `UART_SEND_PARITY_EN`.
- **Defined:**
  - A PARITY state is inserted between D7 and STOP, lasting DIV clocks, with `uart_tx` = even parity (XOR of the latched `Data`).
  - The frame is 11 bits; `tx_done` rises at edge k+1+11·DIV.
- **Undefined:** 8N1 frame as above, with no parity logic present.

## Structure
- **Shared package `uart_pkg`, holding:**
  - the state enumeration;
  - the `Baud_set` to DIV function, computed from `CLK_FREQ`; this function is shared with `recieve`;
  - frame-length constants (10, or 11 with parity).
- **Sub-module `uart_baud_gen`:**
  - inputs: latched DIV, enable, clear;
  - output: a one-cycle `bit_end` pulse when the counter reaches DIV−1.
- The top level holds the FSM, bit index, shift/latch register and output registers.

## Test plan
- `Baud_set`=0, `Data`=8'hAB, one-cycle `send_go`:
  - line reads 0,1,1,0,1,0,1,0,1,1, each bit 434 clocks;
  - `tx_done` occurs exactly 4341 clocks after accept;
  - `tx_busy` is high for 4340 cycles.
- Loopback into `recieve` (`Baud_set`=0), sending 8'hAB then 8'hCD with `send_go` held high: `recieve` outputs `Data`=8'hAB then 8'hCD, each with `rx_done`, and the two frames are 4341 clocks apart.
- `Baud_set`=4, `Data`=8'h55: every bit is 5208 clocks. Changing `Baud_set` to 0 and `Data` to 8'hFF mid-frame has no effect on the frame in progress.
- `send_go` pulsed during DATA: ignored, exactly one `tx_done` occurs, and the line returns high.
- `rst` asserted during bit D3: `uart_tx`=1 and `tx_busy`=0 immediately, no `tx_done`. The next `send_go` after release sends a complete, correct frame.
- With `UART_SEND_PARITY_EN` defined, `Data`=8'hAB (five ones): parity bit = 1, the stop bit follows it, and `tx_done` occurs at accept+4775 clocks.
